// File: rtl/net_tx_mux.sv
// Frame-granular round-robin multiplexer merging CH_NUM protocol tx streams onto one net tx stream.
// Define NET_TX_MUX_IFG_EN to compile in the inter-frame GAP state and its gap counter.
module net_tx_mux #(
  parameter int CH_NUM          = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int IFG_CYCLES      = 12
) (
  input  logic                         logic_clk,
  input  logic                         logic_rst,
  input  logic [CH_NUM*DATA_WIDTH-1:0] ch_tdata_in,
  input  logic [CH_NUM-1:0]            ch_tvalid_in,
  output logic [CH_NUM-1:0]            ch_tready_out,
  input  logic [CH_NUM-1:0]            ch_tlast_in,
  output logic [DATA_WIDTH-1:0]        net_tdata_out,
  output logic                         net_tvalid_out,
  input  logic                         net_tready_in,
  output logic                         net_tlast_out,
  output logic [CH_NUM-1:0]            grant_out,
  output logic                         len_err_out
);

  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam int SEL_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
`ifdef NET_TX_MUX_IFG_EN
  localparam logic [1:0] ST_GAP  = 2'd3;
  localparam logic [1:0] ST_DONE = ST_GAP;
  localparam int         GAP_W   = $clog2(IFG_CYCLES + 1);
`else
  localparam logic [1:0] ST_DONE = ST_IDLE;
`endif

  if (CH_NUM < 1 || CH_NUM > 8 || DATA_WIDTH < 1 || MAX_FRAME_BYTES < 2 || IFG_CYCLES < 1)
  begin : g_param_check
    $error("net_tx_mux: parameter out of range");
  end

  logic [1:0]            state_q, state_d;
  logic [CH_NUM-1:0]     grant_q, grant_d;
  logic [SEL_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  len_err_q, len_err_d;
`ifdef NET_TX_MUX_IFG_EN
  logic [GAP_W-1:0]      gap_q, gap_d;
`endif

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  force_last;
  logic                  rr_found;
  logic [SEL_W-1:0]      rr_idx;
  logic [CH_NUM-1:0]     rr_onehot;

  // The one-hot grant steers the selected channel onto the net side.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (grant_q[i]) begin
        sel_data  = ch_tdata_in[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = ch_tvalid_in[i];
        sel_last  = ch_tlast_in[i];
      end
    end
  end

  // Search order starts one past the previous winner and wraps.
  always_comb begin
    rr_found  = 1'b0;
    rr_idx    = '0;
    rr_onehot = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (!rr_found && (i == (int'(last_q) + k) % CH_NUM) && ch_tvalid_in[i]) begin
          rr_found     = 1'b1;
          rr_idx       = SEL_W'(i);
          rr_onehot[i] = 1'b1;
        end
      end
    end
  end

  assign force_last = (cnt_q == CNT_W'(MAX_FRAME_BYTES - 1)) && !sel_last;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
`ifdef NET_TX_MUX_IFG_EN
    gap_d     = (state_q == ST_GAP) ? gap_q : '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d = rr_onehot;
          last_d  = rr_idx;
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (sel_valid && net_tready_in) begin
          if (sel_last) begin
            state_d = ST_DONE;
          end else if (force_last) begin
            len_err_d = 1'b1;
            state_d   = ST_DROP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DROP: begin
        // Ready is held high here, so any valid beat is consumed.
        if (sel_valid && sel_last) state_d = ST_DONE;
      end
`ifdef NET_TX_MUX_IFG_EN
      ST_GAP: begin
        if (gap_q == GAP_W'(IFG_CYCLES - 1)) state_d = ST_IDLE;
        else                                 gap_d   = gap_q + 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    net_tdata_out  = '0;
    net_tvalid_out = 1'b0;
    net_tlast_out  = 1'b0;
    ch_tready_out  = '0;
    grant_out      = '0;
    if (state_q == ST_XFER) begin
      net_tdata_out  = sel_data;
      net_tvalid_out = sel_valid;
      net_tlast_out  = sel_last || force_last;
      ch_tready_out  = net_tready_in ? grant_q : '0;
      grant_out      = grant_q;
    end else if (state_q == ST_DROP) begin
      ch_tready_out  = grant_q;
      grant_out      = grant_q;
    end
  end

  assign len_err_out = len_err_q;

  // NOTE: all control state is reset; the data path is pure combinational steering and holds no storage.
  always_ff @(posedge logic_clk or negedge logic_rst) begin
    if (!logic_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= SEL_W'(CH_NUM - 1);
      cnt_q     <= '0;
      len_err_q <= 1'b0;
`ifdef NET_TX_MUX_IFG_EN
      gap_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
`ifdef NET_TX_MUX_IFG_EN
      gap_q     <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_net_tx_mux.sv
// Randomised scoreboard bench for net_tx_mux: a frame-level round-robin model predicts the net stream,
// spacing, truncation and len_err timing; a monitor compares every accepted net beat.
module tb_net_tx_mux;

  localparam int CH   = 3;
  localparam int DW   = 8;
  localparam int MAXF = 64;
  localparam int IFG  = 12;
`ifdef NET_TX_MUX_IFG_EN
  localparam int GAPX = IFG;
`else
  localparam int GAPX = 0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    int            ch;
    bit            trunc;
    bit            chk_gap;
    int            gap;
    bit            chk_lat;
  } exp_t;

  logic              logic_clk     = 1'b0;
  logic              logic_rst     = 1'b0;
  logic [CH*DW-1:0]  ch_tdata_in   = '0;
  logic [CH-1:0]     ch_tvalid_in  = '0;
  logic [CH-1:0]     ch_tready_out;
  logic [CH-1:0]     ch_tlast_in   = '0;
  logic [DW-1:0]     net_tdata_out;
  logic              net_tvalid_out;
  logic              net_tready_in = 1'b0;
  logic              net_tlast_out;
  logic [CH-1:0]     grant_out;
  logic              len_err_out;

  net_tx_mux #(
    .CH_NUM(CH), .DATA_WIDTH(DW), .MAX_FRAME_BYTES(MAXF), .IFG_CYCLES(IFG)
  ) dut (
    .logic_clk(logic_clk), .logic_rst(logic_rst),
    .ch_tdata_in(ch_tdata_in), .ch_tvalid_in(ch_tvalid_in), .ch_tready_out(ch_tready_out),
    .ch_tlast_in(ch_tlast_in), .net_tdata_out(net_tdata_out), .net_tvalid_out(net_tvalid_out),
    .net_tready_in(net_tready_in), .net_tlast_out(net_tlast_out), .grant_out(grant_out),
    .len_err_out(len_err_out)
  );

  always #5 logic_clk = ~logic_clk;

  int cyc = 0;
  always @(posedge logic_clk) cyc <= cyc + 1;

  beat_t stg[CH][$];
  beat_t chq[CH][$];
  exp_t  exp_q[$];
  int    rr_last       = CH - 1;
  int    bp_mode       = 0;
  bit    bub_en        = 1'b0;
  int    rise_cyc      = -100;
  int    last_beat_cyc = -100;
  int    trunc_cyc     = -100;
  int    beats_seen    = 0;
  int    n_pass        = 0;
  int    n_total       = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit stg_left();
    for (int c = 0; c < CH; c++) if (stg[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit chq_left();
    for (int c = 0; c < CH; c++) if (chq[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush_all();
    for (int c = 0; c < CH; c++) begin
      stg[c].delete();
      chq[c].delete();
    end
    exp_q.delete();
  endtask

  task automatic add_frame(input int c, input int len, input bit seq);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = seq ? DW'(i) : DW'($urandom);
      b.last = (i == len - 1);
      stg[c].push_back(b);
    end
  endtask

  // Reference model: serve channels with pending frames in round-robin order; each frame delivers at
  // most MAXF beats, the MAXF-th one forced last; trailing beats are swallowed and delay the next frame.
  task automatic launch(input bit timed);
    bit    have_prev;
    int    prev_r;
    int    c;
    int    n;
    beat_t b;
    exp_t  e;
    have_prev = 1'b0;
    prev_r    = 0;
    @(negedge logic_clk);
    while (stg_left()) begin
      c = rr_last;
      do c = (c + 1) % CH; while (stg[c].size() == 0);
      rr_last = c;
      n = 0;
      do begin
        b = stg[c].pop_front();
        chq[c].push_back(b);
        n++;
        if (n <= MAXF) begin
          e.data    = b.data;
          e.last    = b.last || (n == MAXF);
          e.ch      = c;
          e.trunc   = (n == MAXF) && !b.last;
          e.chk_gap = timed && (n == 1) && have_prev;
          e.gap     = 2 + GAPX + prev_r;
          e.chk_lat = timed && (n == 1) && !have_prev;
          exp_q.push_back(e);
        end
      end while (!b.last);
      prev_r    = (n > MAXF) ? n - MAXF : 0;
      have_prev = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() > 0 || chq_left()) && t < budget) begin
      @(negedge logic_clk);
      t++;
    end
    check("drain_within_budget", t < budget, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    flush_all();
    repeat (GAPX + 6) @(negedge logic_clk);
  endtask

  // Per-channel sources: hold each beat until accepted, bubbles only after a frame's first beat.
  initial begin : driver
    bit acc [CH];
    bit mid [CH];
    bit any_prev;
    for (int i = 0; i < CH; i++) mid[i] = 1'b0;
    forever begin
      @(negedge logic_clk);
      for (int i = 0; i < CH; i++) acc[i] = ch_tvalid_in[i] && ch_tready_out[i];
      any_prev = |ch_tvalid_in;
      @(posedge logic_clk);
      #1;
      for (int i = 0; i < CH; i++) begin
        if (acc[i] && chq[i].size() > 0) begin
          mid[i] = !chq[i][0].last;
          void'(chq[i].pop_front());
        end
        if (chq[i].size() > 0 && !(mid[i] && bub_en && $urandom_range(3) == 0)) begin
          ch_tvalid_in[i]             = 1'b1;
          ch_tdata_in[i*DW +: DW]     = chq[i][0].data;
          ch_tlast_in[i]              = chq[i][0].last;
        end else begin
          ch_tvalid_in[i] = 1'b0;
        end
      end
      case (bp_mode)
        1:       net_tready_in = ~net_tready_in;
        2:       net_tready_in = ($urandom_range(1) == 1);
        default: net_tready_in = 1'b1;
      endcase
      if (!any_prev && (|ch_tvalid_in)) rise_cyc = cyc;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge logic_clk);
      if (logic_rst) begin
        if (len_err_out || (cyc == trunc_cyc + 1))
          check("len_err_pulse", len_err_out, cyc == trunc_cyc + 1);
        if (grant_out == '0)
          check("idle_outputs_zero", {ch_tready_out, net_tvalid_out, net_tlast_out, net_tdata_out}, '0);
        if (net_tvalid_out && exp_q.size() > 0)
          check("ready_routing", ch_tready_out, net_tready_in ? (CH'(1) << exp_q[0].ch) : '0);
        if (net_tvalid_out && net_tready_in) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", net_tdata_out, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", net_tdata_out, e.data);
            check("beat_last", net_tlast_out, e.last);
            check("beat_grant", grant_out, CH'(1) << e.ch);
            if (e.chk_gap) check("frame_spacing", cyc - last_beat_cyc, e.gap);
            if (e.chk_lat) check("arb_latency", cyc - rise_cyc, 1);
            if (e.trunc) trunc_cyc = cyc;
            if (e.last) last_beat_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin : main
    int base;
    int t;
    #1;
    check("rst_net_tdata", net_tdata_out, 0);
    check("rst_net_tvalid", net_tvalid_out, 0);
    check("rst_net_tlast", net_tlast_out, 0);
    check("rst_ch_tready", ch_tready_out, 0);
    check("rst_grant", grant_out, 0);
    check("rst_len_err", len_err_out, 0);
    repeat (3) @(negedge logic_clk);
    logic_rst = 1'b1;
    repeat (2) @(negedge logic_clk);

    // Round-robin: all three pending, ch0 has two frames.
    add_frame(0, 4, 1'b0); add_frame(0, 4, 1'b0); add_frame(1, 4, 1'b0); add_frame(2, 4, 1'b0);
    launch(1'b1);
    drain(2000);

    // Single 60-beat sequential frame on ch1.
    add_frame(1, 60, 1'b1);
    launch(1'b1);
    drain(2000);

    // Toggling backpressure during a 10-beat ch2 frame.
    bp_mode = 1;
    add_frame(2, 10, 1'b1);
    launch(1'b0);
    drain(2000);
    bp_mode = 0;

    // Length boundaries around MAXF, with truncation drops followed by normal frames.
    add_frame(0, MAXF + 6, 1'b1); add_frame(0, 5, 1'b0); add_frame(1, MAXF, 1'b0);
    add_frame(2, MAXF - 1, 1'b0); add_frame(1, MAXF + 1, 1'b0);
    launch(1'b1);
    drain(4000);

    // Random frames, full-rate then with bubbles and random backpressure.
    for (int r = 0; r < 6; r++) begin
      bp_mode = (r == 0) ? 0 : 2;
      bub_en  = (r != 0);
      for (int c = 0; c < CH; c++)
        for (int f = 0; f < int'($urandom_range(3)); f++)
          add_frame(c, $urandom_range(1, MAXF + 16), 1'b0);
      if (!stg_left()) add_frame(r % CH, 3, 1'b0);
      launch(r == 0);
      drain(6000);
    end
    bp_mode = 0;
    bub_en  = 1'b0;

    // Asynchronous reset in the middle of a ch1 frame, then ch0 must win first.
    base = beats_seen;
    add_frame(1, 10, 1'b1);
    launch(1'b0);
    t = 0;
    while (beats_seen < base + 5 && t < 500) begin
      @(negedge logic_clk);
      t++;
    end
    check("reach_beat5", t < 500, 1);
    @(posedge logic_clk);
    #3;
    logic_rst = 1'b0;
    #1;
    check("midrst_net_tvalid", net_tvalid_out, 0);
    check("midrst_net_tlast", net_tlast_out, 0);
    check("midrst_net_tdata", net_tdata_out, 0);
    check("midrst_ch_tready", ch_tready_out, 0);
    check("midrst_grant", grant_out, 0);
    check("midrst_len_err", len_err_out, 0);
    flush_all();
    rr_last   = CH - 1;
    trunc_cyc = -100;
    repeat (2) @(negedge logic_clk);
    logic_rst = 1'b1;
    add_frame(1, 3, 1'b0); add_frame(0, 3, 1'b0);
    launch(1'b1);
    drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/net_tx_mux.md
# net_tx_mux

Parametrised transmit-side frame multiplexer for the network path. It merges CH_NUM per-protocol byte streams (ARP, ICMP, UDP, …) onto the single net tx stream. Arbitration is frame-granular round-robin, and a length watchdog truncates runaway frames. It sits between the protocol tx engines and the net tx output of the network top, and replaces the direct single-source tx assignment.

## Interface
- CH_NUM, 3, number of source channels, 1..8
- DATA_WIDTH, 8, beat width in bits
- MAX_FRAME_BYTES, 1518, maximum beats per frame before forced truncation, ≥2
- IFG_CYCLES, 12, idle cycles between frames when NET_TX_MUX_IFG_EN is defined, ≥1
- logic_clk  in  1  single clock for the whole block
- logic_rst  in  1  reset, asynchronous, active-low
- ch_tdata_in  in  CH_NUM*DATA_WIDTH  per-channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_tvalid_in  in  CH_NUM  per-channel valid
- ch_tready_out  out  CH_NUM  per-channel ready
- ch_tlast_in  in  CH_NUM  per-channel end of frame
- net_tdata_out  out  DATA_WIDTH  merged data
- net_tvalid_out  out  1  merged valid
- net_tready_in  in  1  downstream ready
- net_tlast_out  out  1  merged end of frame
- grant_out  out  CH_NUM  one-hot owner of the current frame; 0 when no channel owns the output
- len_err_out  out  1  one-cycle pulse when a frame is truncated

## Operation
- A beat is accepted on a cycle where valid and ready are both high.
- The state register has four states: IDLE, XFER, DROP and GAP. GAP exists only with the macro defined.
- IDLE:
  - grant_out is 0.
  - If any ch_tvalid_in bit is high, the next channel is chosen by round-robin. The search starts at last_grant+1 (mod CH_NUM) and takes the first valid channel in that order.
  - The grant and last_grant are registered, and the state moves to XFER.
- XFER, combinational pass-through of the selected channel sel:
  - net_tdata_out = ch_tdata_in[sel]
  - net_tvalid_out = ch_tvalid_in[sel]
  - ch_tready_out[sel] = net_tready_in
  - All other ch_tready_out bits are 0.
  - net_tlast_out = ch_tlast_in[sel] OR the forced-last condition.
- Beat counter:
  - Width is $clog2(MAX_FRAME_BYTES+1).
  - Cleared on entry to XFER; increments on each beat accepted in XFER.
- Forced last: counter == MAX_FRAME_BYTES-1 and ch_tlast_in[sel] == 0.
  - On that beat, net_tlast_out is driven to 1.
  - When the beat is accepted, len_err_out pulses on the next cycle and the state moves to DROP.
- End of frame: an accepted beat with ch_tlast_in[sel] == 1 moves the state to GAP, or to IDLE if the macro is undefined.
- DROP:
  - net_tvalid_out is 0, ch_tready_out[sel] is 1, grant_out keeps sel.
  - Beats from sel are discarded until one with tlast is accepted, then the state moves to GAP or IDLE.
- Outside XFER: net_tdata_out, net_tlast_out and net_tvalid_out are all 0.
- Channels not granted are never acknowledged; their data must be held stable per the valid/ready rule.
- A channel dropping ch_tvalid_in mid-frame is a legal bubble and does not end the frame.
- CH_NUM == 1: arbitration degenerates to always granting channel 0; state behaviour is unchanged.

## Timing
- Reset (logic_rst low, asynchronous):
  - State goes to IDLE; last_grant = CH_NUM-1, so channel 0 wins first; the beat counter is 0.
  - Every output is 0: net_tdata_out, net_tvalid_out, net_tlast_out, ch_tready_out, grant_out, len_err_out.
- Reset asserted mid-frame: the frame is abandoned immediately with no tlast emitted. After release the block starts in IDLE.
- Arbitration latency: ch_tvalid_in rising in IDLE at cycle N gives grant_out valid and the first beat presentable at cycle N+1.
- Data path: zero-cycle latency in XFER; at most one beat per cycle.
- Frame-to-frame spacing, from the last accepted beat at cycle N to the next frame's first beat:
  - Macro undefined: N+2, because of one IDLE arbitration cycle.
  - Macro defined: N+2+IFG_CYCLES.
- Truncation: a frame delivers exactly MAX_FRAME_BYTES beats on net, the last with net_tlast_out = 1.
- Simultaneous requests: round-robin order guarantees each requesting channel is served within CH_NUM frames.

## Configuration
- NET_TX_MUX_IFG_EN:
  - Defined: the GAP state and a $clog2(IFG_CYCLES+1)-bit gap counter are compiled in. After each frame end or drop completion, the block holds IDLE-equivalent outputs (grant_out = 0, no readies) for IFG_CYCLES cycles, then moves to IDLE.
  - Undefined: no GAP state and no gap counter; frame end goes straight to IDLE.

## Test plan
- Single frame: ch1 sends 60 beats 0x00..0x3B with tlast on beat 60, net_tready_in held 1 → net carries identical beats; grant_out = 3'b010 from the cycle after valid rises through the tlast beat; len_err_out stays 0.
- Round-robin: ch0, ch1 and ch2 all hold a pending 4-beat frame → frames emerge in order ch0, ch1, ch2, ch0; grant_out never changes inside a frame.
- Backpressure: net_tready_in toggles 1,0,1,0 during a 10-beat ch2 frame → no beat is lost or duplicated; ch_tready_out[2] mirrors net_tready_in; the other ready bits stay 0.
- Truncation (MAX_FRAME_BYTES = 16): ch0 sends 20 beats with tlast on beat 20 → net shows 16 beats, tlast on the 16th; len_err_out pulses for 1 cycle; beats 17..20 are consumed silently; the next frame arbitrates normally.
- IFG (macro defined, IFG_CYCLES = 12): two back-to-back ch0 frames → 14 cycles from the first frame's last beat to the second frame's first beat. Same test with the macro undefined → 2 cycles.
- Reset mid-frame: logic_rst pulled low at beat 5 of a ch1 frame → all outputs are 0 asynchronously. After release, ch0 and ch1 both request → ch0 is granted first.
